// File: rtl/stall_ctrl.sv
// Hazard/stall control: load-use, branch-operand and multiply/divide-busy stalls.
// Multiply/divide tracking is compiled in only when STALL_CTRL_MD_UNIT_EN is defined.
module stall_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrD,
  input  logic [31:0] instrE,
  input  logic [31:0] instrM,
  output logic        stall,
  output logic        md_start,
  output logic        md_busy,
  output logic [3:0]  md_count
);

  function automatic logic f_cal_r(input logic [31:0] i);
    return (i[31:26] == 6'h00) &&
           (i[5:0] == 6'h21 || i[5:0] == 6'h23 || i[5:0] == 6'h24 ||
            i[5:0] == 6'h25 || i[5:0] == 6'h2A);
  endfunction

  function automatic logic f_cal_i(input logic [31:0] i);
    return (i[31:26] == 6'h09) || (i[31:26] == 6'h0D) || (i[31:26] == 6'h0F);
  endfunction

  function automatic logic f_load(input logic [31:0] i);
    return i[31:26] == 6'h23;
  endfunction

  function automatic logic f_branch(input logic [31:0] i);
    return (i[31:26] == 6'h04) || (i[31:26] == 6'h05);
  endfunction

  function automatic logic f_jr(input logic [31:0] i);
    return (i[31:26] == 6'h00) && (i[5:0] == 6'h08);
  endfunction

  logic [4:0] w_rs_D, w_rt_D, w_rt_E, w_rd_E, w_rt_M;
  logic [4:0] w_dst_E, w_dst_M;
  logic       w_nop_D, w_load_use, w_rs_hit, w_rt_hit, w_branch_stall;
  logic       w_br_D, w_jr_D;
  logic       w_unused;

  assign w_rs_D  = instrD[25:21];
  assign w_rt_D  = instrD[20:16];
  assign w_rt_E  = instrE[20:16];
  assign w_rd_E  = instrE[15:11];
  assign w_rt_M  = instrM[20:16];
  assign w_nop_D = (instrD == '0);
  assign w_br_D  = f_branch(instrD);
  assign w_jr_D  = f_jr(instrD);

  assign w_load_use = !w_nop_D && f_load(instrE) && (w_rt_E != 5'd0) &&
                      ((w_rt_E == w_rs_D) || (w_rt_E == w_rt_D));

  // A stage that writes nothing reports destination 0, which the non-zero source guard never matches.
  assign w_dst_E = f_cal_r(instrE) ? w_rd_E : (f_cal_i(instrE) ? w_rt_E : 5'd0);
  assign w_dst_M = f_load(instrM) ? w_rt_M : 5'd0;

  assign w_rs_hit = (w_rs_D != 5'd0) && ((w_rs_D == w_dst_E) || (w_rs_D == w_dst_M));
  assign w_rt_hit = (w_rt_D != 5'd0) && ((w_rt_D == w_dst_E) || (w_rt_D == w_dst_M));

  assign w_branch_stall = !w_nop_D &&
                          (((w_br_D || w_jr_D) && w_rs_hit) || (w_br_D && w_rt_hit));

  assign w_unused = ^{clk, reset, instrD[15:6], instrE[25:21], instrE[10:6],
                      instrM[25:21], instrM[15:0]};

`ifdef STALL_CTRL_MD_UNIT_EN
  typedef enum logic {S_IDLE, S_BUSY} md_state_t;

  function automatic logic f_mult(input logic [31:0] i);
    return (i[31:26] == 6'h00) && (i[5:0] == 6'h18 || i[5:0] == 6'h19);
  endfunction

  function automatic logic f_div(input logic [31:0] i);
    return (i[31:26] == 6'h00) && (i[5:0] == 6'h1A || i[5:0] == 6'h1B);
  endfunction

  function automatic logic f_md_use(input logic [31:0] i);
    return ((i[31:26] == 6'h00) && (i[5:0] >= 6'h10) && (i[5:0] <= 6'h13)) ||
           f_mult(i) || f_div(i);
  endfunction

  md_state_t  r_state;
  logic [3:0] r_count;
  logic       w_mult_E, w_div_E, w_md_start, w_md_busy, w_md_stall;

  assign w_mult_E   = f_mult(instrE);
  assign w_div_E    = f_div(instrE);
  assign w_md_start = !reset && (w_mult_E || w_div_E);
  assign w_md_busy  = w_md_start || (r_state == S_BUSY);
  assign w_md_stall = !reset && !w_nop_D && f_md_use(instrD) && w_md_busy;

  // r_state tracks r_count != 0, so BUSY leaves exactly when the count steps from 1 to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_state <= S_IDLE;
    end else if (w_md_start) begin
      r_count <= w_mult_E ? 4'd5 : 4'd10;
      r_state <= S_BUSY;
    end else if (r_state == S_BUSY) begin
      r_count <= r_count - 4'd1;
      if (r_count == 4'd1)
        r_state <= S_IDLE;
    end
  end

  assign md_start = w_md_start;
  assign md_busy  = w_md_busy;
  assign md_count = r_count;
  assign stall    = w_load_use || w_branch_stall || w_md_stall;
`else
  assign md_start = 1'b0;
  assign md_busy  = 1'b0;
  assign md_count = '0;
  assign stall    = w_load_use || w_branch_stall;
`endif

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port instrD, input, 32, instruction word in Decode.
REQ-004 SHALL have port instrE, input, 32, instruction word in Execute.
REQ-005 SHALL have port instrM, input, 32, instruction word in Memory.
REQ-006 SHALL have port stall, output, 1, freezes PC and the F/D register and clears the D/E register (bubble).
REQ-007 SHALL have port md_start, output, 1, multiply/divide unit start pulse.
REQ-008 SHALL have port md_busy, output, 1, multiply/divide unit occupied.
REQ-009 SHALL have port md_count, output, 4, remaining busy cycles.

Function
REQ-010 SHALL decode each stage with field rules:
- rs=[25:21], rt=[20:16], rd=[15:11].
- cal_r: op 0 with funct 0x21, 0x23, 0x24, 0x25 or 0x2A.
- cal_i: op 0x09, 0x0D or 0x0F.
- load: op 0x23.
- branch: op 0x04 or 0x05.
- jr: op 0 with funct 0x08.
- mult-class: op 0, funct 0x18 or 0x19.
- div-class: op 0, funct 0x1A or 0x1B.
- md-use: op 0, funct 0x10 to 0x13, or mult-class, or div-class.
REQ-011 SHALL assert load-use stall when load_E, rt_E!=0, and rt_E equals rs_D or rt_D.
REQ-012 SHALL assert branch stall when branch_D or jr_D reads a register (rs_D, or rt_D for branch only) that is written by any of:
- cal_r_E (dest rd_E);
- cal_i_E (dest rt_E);
- load_M (dest rt_M).
Destination 0 never matches.
REQ-013 SHALL hold a 4-bit down-counter with two states:
- IDLE: count==0.
- BUSY: count!=0.
REQ-014 SHALL pulse md_start combinationally whenever instrE is mult-class or div-class.
REQ-015 SHALL load the counter on md_start: 5 for mult-class, 10 for div-class.
REQ-016 SHALL decrement the counter by 1 per cycle in BUSY when md_start is low, with no wrap below 0.
REQ-017 SHALL give md_start priority over decrement: a new md op arriving while BUSY reloads the counter.
REQ-018 SHALL drive md_busy = md_start OR (count!=0).
REQ-019 SHALL assert md stall when instrD is md-use and md_busy=1.
REQ-020 SHALL drive stall as the OR of load-use, branch and md stalls; it is purely combinational, zero latency.
REQ-021 SHALL drive md_count equal to the counter register.
REQ-022 SHALL ignore instrD==0 (nop) for all stall terms.

Reset
REQ-023 SHALL, while reset=1, force the counter to 0 asynchronously and gate md_start and md stall to 0; md_busy=0 and md_count=0.
REQ-024 SHALL, on reset asserted mid-operation (BUSY), discard the outstanding count; the first cycle after release is IDLE.
REQ-025 SHALL let load-use and branch stall terms follow the inputs even during reset.

Configuration
REQ-026 SHALL compile in the multiply/divide tracking logic only when macro STALL_CTRL_MD_UNIT_EN is defined.
REQ-027 SHALL, without STALL_CTRL_MD_UNIT_EN:
- tie md_start, md_busy and md_count to 0;
- remove the counter;
- make stall the OR of load-use and branch terms only.
Ports remain present.

Verification
REQ-028 SHALL check load-use: instrE=lw $8,0($0), instrD=addu $9,$8,$1 -> stall=1; same with lw $0 -> stall=0.
REQ-029 SHALL check branch stall: instrE=addu $3,$1,$2, instrD=beq $3,$4 -> stall=1; then instrE=nop, instrM=lw $3 -> stall=1; instrM=nop -> stall=0.
REQ-030 SHALL check mult then mflo: instrE=mult $1,$2 -> md_start=1, md_count=5 next cycle; mflo held in D -> stall=1 for 5 cycles, released when md_count reaches 0.
REQ-031 SHALL check div latency: div in E -> md_count=10, 9, ..., 1, 0 over 10 cycles; md_busy falls in the cycle count reads 0.
REQ-032 SHALL check reset mid-operation: reset asserted at md_count=6 -> md_count=0, md_busy=0 immediately, stall=0 for mflo in D.
REQ-033 SHALL check a build without STALL_CTRL_MD_UNIT_EN: mult in E with mflo in D -> stall=0, md_start=0.
